// File: rtl/dsram_arbiter.sv
// Round-robin arbiter sharing one data SRAM port between the pipeline (m0)
// and a secondary master (m1); routes pipelined read data back by issuing id.
module dsram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic [DATA_W/8-1:0]   m0_wen,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,

  input  logic                  m1_req,
  input  logic [DATA_W/8-1:0]   m1_wen,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,

  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_wen,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,

  output logic                  stallreq
);

  localparam int unsigned BE_W = DATA_W / 8;

  // prio_q: 0 favours m0, 1 favours m1 when both request
  logic              prio_q, prio_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_id_q, tag_id_d;
  logic              rd_issue;
  logic              out_vld;
  logic              out_id;

  // Grant, SRAM request mux and stall; everything gated while reset is low
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    stallreq   = 1'b0;
    prio_d     = prio_q;

    if (rst) begin
      m0_gnt   = m0_req & (~m1_req | ~prio_q);
      m1_gnt   = m1_req & (~m0_req |  prio_q);
      stallreq = m0_req & ~m0_gnt;
    end

    sram_en = m0_gnt | m1_gnt;
    if (m0_gnt) begin
      sram_wen   = m0_wen;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
      prio_d     = 1'b1;
    end else if (m1_gnt) begin
      sram_wen   = m1_wen;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
      prio_d     = 1'b0;
    end
  end

  assign rd_issue = sram_en & (sram_wen == BE_W'(0));

  // Tag shift register: one {valid, id} per outstanding read cycle
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = rd_issue;
    tag_id_d[0]  = m1_gnt;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  assign out_vld = tag_vld_q[RD_LAT-1];
  assign out_id  = tag_id_q[RD_LAT-1];

  // Response routing; the master not being answered sees zero data
  assign m0_rvalid = out_vld & ~out_id;
  assign m1_rvalid = out_vld &  out_id;
  assign m0_rdata  = m0_rvalid ? sram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed bench for dsram_arbiter: a RD_LAT=1 instance (a_*) and a RD_LAT=3
// instance (b_*) share clock, reset and master stimulus, each with its own SRAM model.
module tb_dsram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [3:0]  m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_sram_en, a_stallreq;
  logic [3:0]  a_sram_wen;
  logic [31:0] a_sram_addr, a_sram_wdata, a_sram_rdata;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_sram_en, b_stallreq;
  logic [3:0]  b_sram_wen;
  logic [31:0] b_sram_addr, b_sram_wdata, b_sram_rdata;
  logic [31:0] b_p0, b_p1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dsram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .sram_en(a_sram_en), .sram_wen(a_sram_wen), .sram_addr(a_sram_addr),
    .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata), .stallreq(a_stallreq)
  );

  dsram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .sram_en(b_sram_en), .sram_wen(b_sram_wen), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata), .stallreq(b_stallreq)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: mem_word = 32'hDEAD_BEEF;
      32'h0000_0000: mem_word = 32'h1111_0000;
      32'h0000_0004: mem_word = 32'h2222_0004;
      32'h0000_0008: mem_word = 32'h3333_0008;
      default:       mem_word = 32'h0;
    endcase
  endfunction

  // SRAM models: read data returns 1 (a) or 3 (b) cycles after a read issue
  always @(posedge clk) begin
    a_sram_rdata <= (a_sram_en && a_sram_wen == 4'h0) ? mem_word(a_sram_addr) : 32'h0;
    b_p0         <= (b_sram_en && b_sram_wen == 4'h0) ? mem_word(b_sram_addr) : 32'h0;
    b_p1         <= b_p0;
    b_sram_rdata <= b_p1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] w0, input logic [31:0] ad0,
                       input logic r1, input logic [3:0] w1, input logic [31:0] ad1);
    m0_req = r0; m0_wen = w0; m0_addr = ad0; m0_wdata = ad0 ^ 32'h5A5A_0000;
    m1_req = r1; m1_wen = w1; m1_addr = ad1; m1_wdata = ad1 ^ 32'hA5A5_0000;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  // Inputs change on the falling edge; checks follow 1ns later
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 4'h0, 32'h100, 1'b1, 4'h0, 32'h4);

    // Reset with both masters requesting: everything must stay 0
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("rst_ctrl_a", 64'({a_m0_gnt, a_m1_gnt, a_sram_en, a_sram_wen, a_stallreq,
                            a_m0_rvalid, a_m1_rvalid}), 64'h0);
      chk("rst_bus_a", {a_sram_addr, a_sram_wdata}, 64'h0);
      chk("rst_rd_a", {a_m0_rdata, a_m1_rdata}, 64'h0);
      chk("rst_ctrl_b", 64'({b_m0_gnt, b_m1_gnt, b_sram_en, b_stallreq,
                            b_m0_rvalid, b_m1_rvalid}), 64'h0);
    end
    cyc(); rst = 1'b1; idle(); #1;
    chk("idle_en_stall", 64'({a_sram_en, a_stallreq, b_sram_en, b_stallreq}), 64'h0);

    // Both request continuously: m0,m1,m0,m1,m0,m1; stall on even cycles
    for (int k = 1; k <= 6; k++) begin
      cyc(); drive(1'b1, 4'h0, 32'h100, 1'b1, 4'h0, 32'h4); #1;
      chk("rr_m0_gnt", 64'(a_m0_gnt), 64'((k % 2) == 1));
      chk("rr_m1_gnt", 64'(a_m1_gnt), 64'((k % 2) == 0));
      chk("rr_stall", 64'(a_stallreq), 64'((k % 2) == 0));
      chk("rr_addr", 64'(a_sram_addr), ((k % 2) == 1) ? 64'h100 : 64'h4);
    end
    cyc(); idle(); #1;
    chk("rr_last_rvalid", 64'({a_m0_rvalid, a_m1_rvalid}), 64'b01);
    chk("rr_last_rdata", 64'(a_m1_rdata), 64'h2222_0004);
    for (int k = 0; k < 4; k++) cyc();

    // Single m0 read, RD_LAT=1
    cyc(); drive(1'b1, 4'h0, 32'h100, 1'b0, 4'h0, 32'h0); #1;
    chk("rd_gnt", 64'({a_m0_gnt, a_m1_gnt, a_sram_en}), 64'b101);
    chk("rd_addr", 64'(a_sram_addr), 64'h100);
    chk("rd_stall", 64'(a_stallreq), 64'h0);
    cyc(); idle(); #1;
    chk("rd_rvalid", 64'({a_m0_rvalid, a_m1_rvalid}), 64'b10);
    chk("rd_m0_rdata", 64'(a_m0_rdata), 64'hDEAD_BEEF);
    chk("rd_m1_rdata", 64'(a_m1_rdata), 64'h0);
    for (int k = 0; k < 3; k++) cyc();

    // m1 partial write produces no response
    cyc(); drive(1'b0, 4'h0, 32'h0, 1'b1, 4'b0011, 32'h20); m1_wdata = 32'h1234; #1;
    chk("wr_gnt_en", 64'({a_m1_gnt, a_sram_en}), 64'b11);
    chk("wr_wen", 64'(a_sram_wen), 64'h3);
    chk("wr_addr", 64'(a_sram_addr), 64'h20);
    chk("wr_wdata", 64'(a_sram_wdata), 64'h1234);
    for (int k = 1; k <= 4; k++) begin
      cyc(); idle(); #1;
      chk("wr_no_rvalid", 64'({a_m1_rvalid, b_m1_rvalid}), 64'h0);
    end
    for (int k = 0; k < 3; k++) cyc();

    // RD_LAT=3 pipelined reads m0,m1,m0
    cyc(); drive(1'b1, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0); #1;
    chk("p3_gnt0", 64'({b_m0_gnt, b_m1_gnt}), 64'b10);
    cyc(); drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h4); #1;
    chk("p3_gnt1", 64'({b_m0_gnt, b_m1_gnt}), 64'b01);
    chk("p3_early1", 64'({b_m0_rvalid, b_m1_rvalid}), 64'h0);
    cyc(); drive(1'b1, 4'h0, 32'h8, 1'b0, 4'h0, 32'h0); #1;
    chk("p3_gnt2", 64'({b_m0_gnt, b_m1_gnt}), 64'b10);
    chk("p3_early2", 64'({b_m0_rvalid, b_m1_rvalid}), 64'h0);
    cyc(); idle(); #1;
    chk("p3_rv3", 64'({b_m0_rvalid, b_m1_rvalid}), 64'b10);
    chk("p3_rd3", {b_m0_rdata, b_m1_rdata}, {32'h1111_0000, 32'h0});
    cyc(); #1;
    chk("p3_rv4", 64'({b_m0_rvalid, b_m1_rvalid}), 64'b01);
    chk("p3_rd4", {b_m0_rdata, b_m1_rdata}, {32'h0, 32'h2222_0004});
    cyc(); #1;
    chk("p3_rv5", 64'({b_m0_rvalid, b_m1_rvalid}), 64'b10);
    chk("p3_rd5", {b_m0_rdata, b_m1_rdata}, {32'h3333_0008, 32'h0});
    cyc(); #1;
    chk("p3_rv6", 64'({b_m0_rvalid, b_m1_rvalid}), 64'h0);
    for (int k = 0; k < 3; k++) cyc();

    // Reset during an outstanding read; prio must return to m0
    cyc(); drive(1'b1, 4'h0, 32'h100, 1'b0, 4'h0, 32'h0); #1;
    chk("mr_gnt", 64'({a_m0_gnt, b_m0_gnt}), 64'b11);
    cyc(); idle(); rst = 1'b0; #1;
    chk("mr_in_rst", 64'({a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid}), 64'h0);
    cyc(); rst = 1'b1; drive(1'b1, 4'hF, 32'h40, 1'b1, 4'hF, 32'h44); #1;
    chk("mr_prio_a", 64'({a_m0_gnt, a_m1_gnt}), 64'b10);
    chk("mr_prio_b", 64'({b_m0_gnt, b_m1_gnt}), 64'b10);
    chk("mr_rv_rel", 64'({a_m0_rvalid, b_m0_rvalid}), 64'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); #1;
      chk("mr_no_rvalid", 64'({a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid}), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
